// File: rtl/wb_bram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_bram_ctrl_pkg
// Purpose  : Shared types and constants for the Wishbone-to-BRAM controller:
//            FSM state encoding, default bus base and counter sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package wb_bram_ctrl_pkg;

  // Controller states; 3 bits cover the five phases of one transfer.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  // Default user-project window on the Caravel bus (only [31:24] decoded).
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3800_0000;

  // Width of the latency counter; it must hold DELAY itself. A zero delay
  // still gets a 1-bit counter so the register never collapses to nothing.
  function automatic int cnt_width(input int delay);
    int w;
    w = $clog2(delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_bram_ctrl
// Purpose  : Wishbone classic slave in front of a single-port block RAM.
//            Decodes a hit, waits DELAY cycles (modelled memory latency),
//            performs one BRAM access, captures the read word and returns a
//            single-cycle acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bram_ctrl
  import wb_bram_ctrl_pkg::*;
#(
  parameter int          N         = 14,
  parameter int          DELAY     = 10,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          bram_en0,
  output logic [3:0]    bram_we0,
  output logic [N-1:0]  bram_a0,
  output logic [31:0]   bram_di0,
  input  logic [31:0]   bram_do0
);

  localparam int          CW      = cnt_width(DELAY);
  localparam logic [CW-1:0] DELAY_C = CW'(DELAY);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [3:0]      sel_q;
  logic            ack_q;
  logic [31:0]     dat_q;
  logic [N-1:0]    a0_q;
  logic [31:0]     di0_q;

  logic            hit;
  logic            access;

  // Upper aliasing bits and the byte offset are deliberately not decoded.
  logic            unused_adr_bits;
  assign unused_adr_bits = ^{wbs_adr_i[23:N+2], wbs_adr_i[1:0]};

  // Request decode: only the top address byte selects this slave.
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);

  // BRAM strobes come straight from the state register and are killed by
  // reset combinationally, so a reset landing in ACCESS never writes.
  assign access   = (state == ST_ACCESS) & ~wb_rst_i;
  assign bram_en0 = access;
  assign bram_we0 = (access & we_q) ? sel_q : 4'b0000;
  assign bram_a0  = a0_q;
  assign bram_di0 = di0_q;

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  // Transfer sequencer: latch request, count latency, access, capture, ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      sel_q <= 4'b0000;
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      a0_q  <= '0;
      di0_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            a0_q  <= wbs_adr_i[N+1:2];
            di0_q <= wbs_dat_i;
            sel_q <= wbs_sel_i;
            we_q  <= wbs_we_i;
            cnt   <= DELAY_C;
            state <= (DELAY == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Dropping the cycle while still waiting cancels the request
          // before the memory is ever touched.
          if (!wbs_cyc_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - ONE_C;
            if (cnt == ONE_C) begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // The access is committed regardless of the bus at this point.
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // bram_do0 is valid now, one cycle after the enable.
          dat_q <= we_q ? 32'h0 : bram_do0;
          if (!wbs_cyc_i) begin
            state <= ST_IDLE;
          end else begin
            ack_q <= 1'b1;
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bram_ctrl
// Purpose  : Directed self-checking bench for wb_bram_ctrl. One instance with
//            DELAY=10 and one with DELAY=0, each wired to a behavioural BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bram_ctrl;

  localparam int N = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT 1 (DELAY = 10) ----------------
  logic        rst1, cyc1, stb1, we1;
  logic [3:0]  sel1;
  logic [31:0] adr1, dat1;
  logic        ack1;
  logic [31:0] dato1;
  logic        en1;
  logic [3:0]  we01;
  logic [N-1:0] a01;
  logic [31:0] di01, do1;
  logic [31:0] mem1 [0:(1<<N)-1];

  wb_bram_ctrl #(.N(N), .DELAY(10), .BASE_ADDR(32'h3800_0000)) u_dut1 (
    .wb_clk_i (clk),   .wb_rst_i (rst1),
    .wbs_cyc_i(cyc1),  .wbs_stb_i(stb1),  .wbs_we_i(we1),
    .wbs_sel_i(sel1),  .wbs_adr_i(adr1),  .wbs_dat_i(dat1),
    .wbs_ack_o(ack1),  .wbs_dat_o(dato1),
    .bram_en0 (en1),   .bram_we0 (we01),  .bram_a0 (a01),
    .bram_di0 (di01),  .bram_do0 (do1)
  );

  // Behavioural single-port BRAM: registered read, byte-lane writes.
  always_ff @(posedge clk) begin
    if (en1) begin
      do1 <= mem1[a01];
      for (int b = 0; b < 4; b++) begin
        if (we01[b]) mem1[a01][8*b +: 8] <= di01[8*b +: 8];
      end
    end
  end

  // ---------------- DUT 2 (DELAY = 0) ----------------
  logic        rst2, cyc2, stb2, we2;
  logic [3:0]  sel2;
  logic [31:0] adr2, dat2;
  logic        ack2;
  logic [31:0] dato2;
  logic        en2;
  logic [3:0]  we02;
  logic [N-1:0] a02;
  logic [31:0] di02, do2;
  logic [31:0] mem2 [0:(1<<N)-1];

  wb_bram_ctrl #(.N(N), .DELAY(0), .BASE_ADDR(32'h3800_0000)) u_dut2 (
    .wb_clk_i (clk),   .wb_rst_i (rst2),
    .wbs_cyc_i(cyc2),  .wbs_stb_i(stb2),  .wbs_we_i(we2),
    .wbs_sel_i(sel2),  .wbs_adr_i(adr2),  .wbs_dat_i(dat2),
    .wbs_ack_o(ack2),  .wbs_dat_o(dato2),
    .bram_en0 (en2),   .bram_we0 (we02),  .bram_a0 (a02),
    .bram_di0 (di02),  .bram_do0 (do2)
  );

  always_ff @(posedge clk) begin
    if (en2) begin
      do2 <= mem2[a02];
      for (int b = 0; b < 4; b++) begin
        if (we02[b]) mem2[a02][8*b +: 8] <= di02[8*b +: 8];
      end
    end
  end

  // ---------------- observation results ----------------
  int          en_cyc, ack_cyc, ack_cnt, en_cnt, wen_cnt;
  logic [3:0]  we_at_en;
  logic [N-1:0] a0_at_en;
  logic [31:0] rdata;
  logic [5:0]  post_rst;
  int          ack2_n;
  int          ack2_cyc [0:1];
  logic [31:0] rd2 [0:1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer on DUT 1, starting just after a rising edge (cycle 0).
  // Optional bus abort or reset injection at a given cycle number.
  task automatic xfer1(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int abort_at, input int rst_at,
                       input int ncyc);
    bit done;
    en_cyc = -1; ack_cyc = -1; ack_cnt = 0; en_cnt = 0; wen_cnt = 0;
    we_at_en = 4'h0; a0_at_en = '0; rdata = 32'h0; post_rst = 6'h3f;
    cyc1 = 1'b1; stb1 = 1'b1; we1 = we; adr1 = adr; dat1 = dat; sel1 = sel;
    done = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (done || k == abort_at) begin cyc1 = 1'b0; stb1 = 1'b0; end
      if (k == rst_at) rst1 = 1'b1;
      if (k == rst_at + 1) begin rst1 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0; end
      @(negedge clk);
      if (k == rst_at + 1) post_rst = {ack1, en1, |we01, |a01, |di01, |dato1};
      if (en1) begin
        en_cnt++;
        if (en_cyc < 0) begin en_cyc = k; we_at_en = we01; a0_at_en = a01; end
      end
      if (we01 != 4'h0) wen_cnt++;
      if (ack1) begin ack_cnt++; ack_cyc = k; rdata = dato1; done = 1'b1; end
      @(posedge clk); #1;
    end
    cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0;
  endtask

  // Transfer(s) on DUT 2 with cyc/stb held for hold cycles; records acks.
  task automatic xfer2(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input int hold, input int ncyc);
    ack2_n = 0; ack2_cyc[0] = -1; ack2_cyc[1] = -1; rd2[0] = 32'h0; rd2[1] = 32'h0;
    cyc2 = 1'b1; stb2 = 1'b1; we2 = we; adr2 = adr; dat2 = dat; sel2 = 4'hF;
    for (int k = 0; k < ncyc; k++) begin
      if (k == hold) begin cyc2 = 1'b0; stb2 = 1'b0; end
      @(negedge clk);
      if (ack2) begin
        if (ack2_n < 2) begin ack2_cyc[ack2_n] = k; rd2[ack2_n] = dato2; end
        ack2_n++;
      end
      @(posedge clk); #1;
    end
    cyc2 = 1'b0; stb2 = 1'b0; we2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0; sel1 = 4'h0; adr1 = 32'h0; dat1 = 32'h0;
    rst2 = 1'b1; cyc2 = 1'b0; stb2 = 1'b0; we2 = 1'b0; sel2 = 4'h0; adr2 = 32'h0; dat2 = 32'h0;
    // A hit presented during reset must be dropped.
    cyc1 = 1'b1; stb1 = 1'b1; adr1 = 32'h3800_0010;
    repeat (3) @(posedge clk);
    #1;
    cyc1 = 1'b0; stb1 = 1'b0; adr1 = 32'h0;
    rst1 = 1'b0; rst2 = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ack",  {31'h0, ack1}, 32'h0);
    check("rst_dat",  dato1,         32'h0);
    check("rst_en",   {31'h0, en1},  32'h0);
    check("rst_we",   {28'h0, we01}, 32'h0);
    check("rst_a0",   {18'h0, a01},  32'h0);
    check("rst_di0",  di01,          32'h0);
    @(posedge clk); #1;

    // Full-word write
    xfer1(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, -1, -5, 18);
    check("wr_en_cyc",  en_cyc,              32'd11);
    check("wr_we",      {28'h0, we_at_en},   32'hF);
    check("wr_a0",      {18'h0, a0_at_en},   32'd4);
    check("wr_ack_cyc", ack_cyc,             32'd13);
    check("wr_ack_cnt", ack_cnt,             32'd1);

    // Read-back (byte offset bits ignored)
    xfer1(1'b0, 32'h3800_0012, 32'h0, 4'hF, -1, -5, 18);
    check("rd_en_cyc",  en_cyc,              32'd11);
    check("rd_we",      {28'h0, we_at_en},   32'h0);
    check("rd_ack_cyc", ack_cyc,             32'd13);
    check("rd_data",    rdata,               32'hDEAD_BEEF);

    // Byte-lane write then read, through an aliased upper address
    xfer1(1'b1, 32'h3840_0010, 32'h0000_AA00, 4'b0010, -1, -5, 18);
    check("bw_we",      {28'h0, we_at_en},   32'h2);
    check("bw_ack_cyc", ack_cyc,             32'd13);
    xfer1(1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, -5, 18);
    check("bw_rd_data", rdata,               32'hDEAD_AAEF);

    // Miss
    xfer1(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, -1, -5, 20);
    check("miss_en",    en_cnt,  32'd0);
    check("miss_we",    wen_cnt, 32'd0);
    check("miss_ack",   ack_cnt, 32'd0);

    // Abort during WAIT
    xfer1(1'b1, 32'h3800_0010, 32'h1111_1111, 4'hF, 5, -5, 20);
    check("abort_en",   en_cnt,  32'd0);
    check("abort_ack",  ack_cnt, 32'd0);
    xfer1(1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, -5, 18);
    check("abort_rd_ack_cyc", ack_cyc, 32'd13);
    check("abort_rd_data",    rdata,   32'hDEAD_AAEF);

    // Reset landing in ACCESS (cycle 11) of a write
    xfer1(1'b1, 32'h3800_0010, 32'h1234_5678, 4'hF, -1, 11, 20);
    check("rst_mid_en",   en_cnt,             32'd0);
    check("rst_mid_we",   wen_cnt,            32'd0);
    check("rst_mid_outs", {26'h0, post_rst},  32'h0);
    check("rst_mid_ack",  ack_cnt,            32'd0);
    xfer1(1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, -5, 18);
    check("rst_mid_rd_data", rdata, 32'hDEAD_AAEF);

    // DELAY = 0: single write, then two back-to-back reads
    xfer2(1'b1, 32'h3800_0040, 32'hCAFE_F00D, 4, 8);
    check("d0_wr_ack_cyc", ack2_cyc[0], 32'd3);
    check("d0_wr_ack_n",   ack2_n,      32'd1);
    xfer2(1'b0, 32'h3800_0040, 32'h0, 8, 12);
    check("d0_rd_ack_n",    ack2_n,      32'd2);
    check("d0_rd_ack0_cyc", ack2_cyc[0], 32'd3);
    check("d0_rd_ack1_cyc", ack2_cyc[1], 32'd7);
    check("d0_rd_data0",    rd2[0],      32'hCAFE_F00D);
    check("d0_rd_data1",    rd2[1],      32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_bram_ctrl.md
# wb_bram_ctrl

Wishbone classic slave that fronts the user-project block RAM. It decodes a request, waits a programmable number of cycles to model external-memory latency, and drives one single-cycle BRAM port access with byte-lane write enables. It captures the read word and returns a one-cycle `wbs_ack_o`. It sits between the Caravel Wishbone bus and the BRAM, drives that RAM's `EN0`/`WE0`/`A0`/`Di0`, and consumes its `Do0`.

## Interface

Parameters:
- `N`, 14, BRAM word-address width; the RAM holds 2^N words.
- `DELAY`, 10, wait cycles inserted before the BRAM access; 0 is legal.
- `BASE_ADDR`, 32'h3800_0000, bus base; only bits [31:24] are decoded.

Ports:
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset; synchronous, active-high
- `wbs_cyc_i`  in  1  bus cycle
- `wbs_stb_i`  in  1  strobe
- `wbs_we_i`  in  1  1 = write
- `wbs_sel_i`  in  4  byte-lane select
- `wbs_adr_i`  in  32  byte address
- `wbs_dat_i`  in  32  write data
- `wbs_ack_o`  out  1  registered acknowledge
- `wbs_dat_o`  out  32  registered read data
- `bram_en0`  out  1  BRAM enable
- `bram_we0`  out  4  BRAM byte write enables
- `bram_a0`  out  N  BRAM word address
- `bram_di0`  out  32  BRAM write data
- `bram_do0`  in  32  BRAM read data; valid one cycle after `EN0`

## Operation

- **Hit condition:** `wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24])`.
  - On a miss the block ignores the request and asserts no output.
  - Address bits [23:N+2] alias. Bits [1:0] are ignored.
- **Request latch (IDLE, on hit):** latch `adr[N+1:2]`, `dat_i`, `sel_i` and `we_i`. Load the counter with `DELAY`.
- **State machine:**
  - IDLE -> WAIT on hit with `DELAY > 0`. IDLE -> ACCESS on hit with `DELAY == 0`.
  - WAIT: decrement the counter. Go to ACCESS when the counter equals 1.
  - WAIT with `wbs_cyc_i` low -> IDLE (abort). No BRAM access occurs.
  - ACCESS: `bram_en0 = 1`. `bram_we0 = we ? sel : 4'b0`. `bram_a0` and `bram_di0` come from the latched request. ACCESS -> CAPTURE.
  - CAPTURE: register `bram_do0` into `wbs_dat_o` on reads; writes load 0. CAPTURE -> ACK.
  - ACK: `wbs_ack_o = 1` for exactly one cycle, then -> IDLE.
- **Abort after WAIT:** once ACCESS is entered, the access commits. If `wbs_cyc_i` is low in CAPTURE, go to IDLE without ACK.
- **BRAM port outputs:** `bram_en0` and `bram_we0` decode from the state register and are gated by `!wb_rst_i`. `bram_a0` and `bram_di0` hold their last latched value.
- **Data output:** `wbs_dat_o` holds the captured value until the next CAPTURE. It is only meaningful while `wbs_ack_o` is high.
- **Sub-word accesses:** byte and halfword writes rely solely on `sel`; there is no read-modify-write.

## Timing

- **Cycle numbering:** cycle 0 is the first cycle in which the hit is sampled in IDLE.
- **ACCESS** occurs in cycle `DELAY+1`.
- **CAPTURE** occurs in cycle `DELAY+2`; `bram_do0` is valid in that cycle.
- **ACK** is high in cycle `DELAY+3`. Reads and writes have identical latency.
- **Back-to-back requests:** the cycle after ACK is IDLE and may accept a new hit. Peak rate is one transfer per `DELAY+4` cycles.
- **Reset values:** the state is IDLE and the counter is 0. All outputs are 0: `wbs_ack_o`, `wbs_dat_o`, `bram_en0`, `bram_we0`, `bram_a0`, `bram_di0`.
- **Reset mid-operation:** reset in any cycle, including ACCESS, produces no BRAM write, because the enable is gated combinationally. From the next cycle the block behaves as just reset, and the interrupted request is never acked.
- **Simultaneous events:** a hit sampled in the reset cycle is dropped. `stb` held high during WAIT, ACCESS or CAPTURE is not re-latched.

## Structure

- **`wb_bram_ctrl_pkg` contents:**
  - the 3-bit state encoding: IDLE, WAIT, ACCESS, CAPTURE, ACK;
  - the `BASE_ADDR` default;
  - the counter-width helper `$clog2(DELAY+1)`.
- **Sub-modules:** none. The counter and FSM are a single module.
- **Parent wiring:** the parent instantiates `bram` alongside this block and connects the `bram_*` ports to it.

## Test plan

All scenarios use `DELAY=10` and a real `bram` model.
- **Full-word write:** write 0xDEADBEEF, sel 4'hF, to 0x3800_0010 -> in cycle 11, `bram_en0=1`, `bram_we0=4'hF`, `bram_a0=4`. `wbs_ack_o` is high only in cycle 13.
- **Read-back:** read 0x3800_0010 -> `bram_we0=0` in cycle 11, and `wbs_dat_o=0xDEADBEEF` with ack in cycle 13.
- **Byte-lane write:** write 0x0000AA00 with sel 4'b0010 to the same address, then read -> 0xDEADAAEF.
- **Miss:** request to 0x3000_0000 held for 20 cycles -> `bram_en0`, `bram_we0` and `wbs_ack_o` stay 0 throughout.
- **Abort:** drop `wbs_cyc_i` in cycle 5 of a write -> no `bram_en0`, no ack, and the memory word is unchanged. The next read completes with ack in its cycle 13.
- **Reset and back-to-back:**
  - assert `wb_rst_i` in cycle 11 of a write -> no write occurs and all outputs are 0 the next cycle;
  - with `DELAY=0`, two back-to-back reads -> acks 4 cycles apart.
